// File: rtl/infix_to_rpn.sv
// Shunting-yard converter: infix ASCII in, space-separated RPN ASCII out,
// terminated by '='. Input and output use a stb/ack byte handshake.
module infix_to_rpn #(
  parameter int STACK_DEPTH = 16,
  parameter int PTR_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_stb,
  input  logic [7:0] in_char,
  output logic       in_ack,
  output logic       out_stb,
  output logic [7:0] out_char,
  input  logic       out_ack,
  output logic       error
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_DECODE     = 4'd1;
  localparam logic [3:0] ST_EMIT_DIGIT = 4'd2;
  localparam logic [3:0] ST_EMIT_SEP   = 4'd3;
  localparam logic [3:0] ST_POP_OP     = 4'd4;
  localparam logic [3:0] ST_POP_SEP    = 4'd5;
  localparam logic [3:0] ST_PUSH       = 4'd6;
  localparam logic [3:0] ST_EMIT_EQ    = 4'd7;
  localparam logic [3:0] ST_ERR        = 4'd8;

  localparam logic [7:0] C_SPACE = 8'h20;
  localparam logic [7:0] C_LPAR  = 8'h28;
  localparam logic [7:0] C_RPAR  = 8'h29;
  localparam logic [7:0] C_MUL   = 8'h2A;
  localparam logic [7:0] C_PLUS  = 8'h2B;
  localparam logic [7:0] C_MINUS = 8'h2D;
  localparam logic [7:0] C_DIV   = 8'h2F;
  localparam logic [7:0] C_EQ    = 8'h3D;

  // Pointer is one bit wider than an index so "full" (== STACK_DEPTH) is representable.
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);

  logic [3:0]       state_reg;
  logic [7:0]       char_reg;
  logic             num_active_reg;
  logic [PTR_W:0]   sp_reg;
  logic [7:0]       stack_mem [STACK_DEPTH];
  logic             in_ack_reg;
  logic             out_stb_reg;
  logic [7:0]       out_char_reg;
  logic             error_reg;

  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_idx;
  logic [7:0]       top_char;
  logic             stack_empty;
  logic             stack_full;
  logic             slot_free;
  logic             push_en;
  logic             char_is_digit;
  logic             char_is_special;
  logic [3:0]       cont_state;
  logic             cont_discard;

  // Binding strength of an operator; '(' and everything else rank 0.
  function automatic logic [1:0] prec_of(input logic [7:0] c);
    logic [1:0] p;
    p = 2'd0;
    if (c == C_MUL || c == C_DIV) p = 2'd2;
    else if (c == C_PLUS || c == C_MINUS) p = 2'd1;
    return p;
  endfunction

  // Low index bits wrap naturally: sp==STACK_DEPTH gives top index STACK_DEPTH-1.
  assign top_idx     = PTR_W'(sp_reg[PTR_W-1:0] - PTR_W'(1));
  assign push_idx    = sp_reg[PTR_W-1:0];
  assign top_char    = stack_mem[top_idx];
  assign stack_empty = (sp_reg == '0);
  assign stack_full  = (sp_reg == SP_FULL);
  // A new output byte may be loaded when the slot is empty or is being taken this edge.
  assign slot_free   = !out_stb_reg || out_ack;
  assign push_en     = (state_reg == ST_PUSH) && !stack_full;

  assign char_is_digit   = (char_reg >= 8'h30) && (char_reg <= 8'h39);
  assign char_is_special = (char_reg == C_PLUS) || (char_reg == C_MINUS) ||
                           (char_reg == C_MUL)  || (char_reg == C_DIV)   ||
                           (char_reg == C_LPAR) || (char_reg == C_RPAR)  ||
                           (char_reg == C_EQ);

  // Where the latched char goes once any separator/popped operator is out.
  always_comb begin
    cont_state   = ST_IDLE;
    cont_discard = 1'b0;
    case (char_reg)
      C_PLUS, C_MINUS, C_MUL, C_DIV: begin
        if (!stack_empty && top_char != C_LPAR &&
            prec_of(top_char) >= prec_of(char_reg))
          cont_state = ST_POP_OP;
        else
          cont_state = ST_PUSH;
      end
      C_LPAR: cont_state = ST_PUSH;
      C_RPAR: begin
        if (stack_empty) begin
          cont_state = ST_ERR;
        end else if (top_char == C_LPAR) begin
          cont_state   = ST_IDLE;
          cont_discard = 1'b1;
        end else begin
          cont_state = ST_POP_OP;
        end
      end
      C_EQ: begin
        if (stack_empty)
          cont_state = ST_EMIT_EQ;
        else if (top_char == C_LPAR)
          cont_state = ST_ERR;
        else
          cont_state = ST_POP_OP;
      end
      default: cont_state = ST_IDLE;
    endcase
  end

  // Operator stack storage; no reset needed, validity is tracked by sp_reg.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= char_reg;
  end

  // Main conversion FSM with input/output handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      char_reg       <= 8'h00;
      num_active_reg <= 1'b0;
      sp_reg         <= '0;
      in_ack_reg     <= 1'b0;
      out_stb_reg    <= 1'b0;
      out_char_reg   <= 8'h00;
      error_reg      <= 1'b0;
    end else begin
      in_ack_reg <= 1'b0;
      if (out_stb_reg && out_ack) out_stb_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (in_stb && !in_ack_reg) begin
            char_reg   <= in_char;
            in_ack_reg <= 1'b1;
            state_reg  <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (char_is_digit) begin
            state_reg <= ST_EMIT_DIGIT;
          end else if (char_reg == C_SPACE || char_is_special) begin
            if (num_active_reg) begin
              state_reg <= ST_EMIT_SEP;
            end else begin
              state_reg <= cont_state;
              if (cont_state == ST_ERR) error_reg <= 1'b1;
              if (cont_discard) sp_reg <= sp_reg - SP_ONE;
            end
          end else begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
          end
        end

        ST_EMIT_DIGIT: begin
          if (slot_free) begin
            out_stb_reg    <= 1'b1;
            out_char_reg   <= char_reg;
            num_active_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end

        ST_EMIT_SEP: begin
          if (slot_free) begin
            out_stb_reg    <= 1'b1;
            out_char_reg   <= C_SPACE;
            num_active_reg <= 1'b0;
            state_reg      <= cont_state;
            if (cont_state == ST_ERR) error_reg <= 1'b1;
            if (cont_discard) sp_reg <= sp_reg - SP_ONE;
          end
        end

        ST_POP_OP: begin
          if (slot_free) begin
            out_stb_reg  <= 1'b1;
            out_char_reg <= top_char;
            sp_reg       <= sp_reg - SP_ONE;
            state_reg    <= ST_POP_SEP;
          end
        end

        ST_POP_SEP: begin
          if (slot_free) begin
            out_stb_reg  <= 1'b1;
            out_char_reg <= C_SPACE;
            state_reg    <= cont_state;
            if (cont_state == ST_ERR) error_reg <= 1'b1;
            if (cont_discard) sp_reg <= sp_reg - SP_ONE;
          end
        end

        ST_PUSH: begin
          if (stack_full) begin
            state_reg <= ST_ERR;
            error_reg <= 1'b1;
          end else begin
            sp_reg    <= sp_reg + SP_ONE;
            state_reg <= ST_IDLE;
          end
        end

        ST_EMIT_EQ: begin
          if (slot_free) begin
            out_stb_reg    <= 1'b1;
            out_char_reg   <= C_EQ;
            num_active_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end

        ST_ERR: begin
          // Swallow input until '=' resynchronises the stream.
          error_reg      <= 1'b1;
          sp_reg         <= '0;
          num_active_reg <= 1'b0;
          if (in_stb && !in_ack_reg) begin
            in_ack_reg <= 1'b1;
            if (in_char == C_EQ) begin
              error_reg <= 1'b0;
              state_reg <= ST_IDLE;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ack   = in_ack_reg;
  assign out_stb  = out_stb_reg;
  assign out_char = out_char_reg;
  assign error    = error_reg;

endmodule

// File: tb/tb_infix_to_rpn.sv
// Self-checking bench for infix_to_rpn: directed and random expressions
// checked against a queue-based shunting-yard model.
module tb_infix_to_rpn;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_stb = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ack;
  logic       out_stb;
  logic [7:0] out_char;
  logic       out_ack = 1'b0;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_mode = 0;   // 0 always ack, 1 random, 2 one ack per 6 cycles, 3 never
  int ack_cnt  = 0;

  byte exp_q[$];
  byte m_stack[$];
  bit  m_num;
  bit  m_err;

  always #5 clk = ~clk;

  infix_to_rpn #(.STACK_DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_stb(in_stb), .in_char(in_char), .in_ack(in_ack),
    .out_stb(out_stb), .out_char(out_char), .out_ack(out_ack),
    .error(error)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int prec(input byte c);
    if (c == "*" || c == "/") return 2;
    if (c == "+" || c == "-") return 1;
    return 0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_stack.delete();
    m_num = 0;
    m_err = 0;
  endtask

  task automatic model_fail();
    m_err = 1;
    m_num = 0;
    m_stack.delete();
  endtask

  task automatic model_char(input byte c);
    if (m_err) begin
      if (c == "=") begin m_err = 0; m_num = 0; end
      return;
    end
    if (c >= "0" && c <= "9") begin
      exp_q.push_back(c);
      m_num = 1;
      return;
    end
    if (!(c == " " || c == "+" || c == "-" || c == "*" || c == "/" ||
          c == "(" || c == ")" || c == "=")) begin
      model_fail();
      return;
    end
    if (m_num) begin exp_q.push_back(8'h20); m_num = 0; end
    if (c == "+" || c == "-" || c == "*" || c == "/") begin
      while (m_stack.size() > 0 && m_stack[$] != "(" && prec(m_stack[$]) >= prec(c)) begin
        exp_q.push_back(m_stack.pop_back());
        exp_q.push_back(8'h20);
      end
      if (m_stack.size() >= 16) model_fail();
      else m_stack.push_back(c);
    end else if (c == "(") begin
      if (m_stack.size() >= 16) model_fail();
      else m_stack.push_back(c);
    end else if (c == ")") begin
      while (m_stack.size() > 0 && m_stack[$] != "(") begin
        exp_q.push_back(m_stack.pop_back());
        exp_q.push_back(8'h20);
      end
      if (m_stack.size() == 0) model_fail();
      else void'(m_stack.pop_back());
    end else if (c == "=") begin
      while (m_stack.size() > 0) begin
        if (m_stack[$] == "(") begin model_fail(); return; end
        exp_q.push_back(m_stack.pop_back());
        exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h3D);
    end
  endtask

  // Pin the model against hand-derived RPN strings.
  task automatic pin(input string s, input string want);
    model_clear();
    for (int i = 0; i < s.len(); i++) model_char(s[i]);
    check($sformatf("pin_len '%s'", s), exp_q.size(), want.len());
    for (int i = 0; i < want.len() && i < exp_q.size(); i++)
      check($sformatf("pin_byte '%s'[%0d]", s, i), exp_q[i], want[i]);
    model_clear();
  endtask

  // ---------------- out_ack driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: out_ack = 1'b1;
        1: out_ack = ($urandom_range(0, 2) != 0);
        2: begin out_ack = ((ack_cnt % 6) == 5); ack_cnt++; end
        default: out_ack = 1'b0;
      endcase
    end
  end

  // ---------------- output compare process ----------------
  initial begin
    bit  prev_stall = 0;
    byte prev_char = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("stall_out_stb", out_stb, 1);
          check("stall_out_char", out_char, prev_char);
        end
        if (out_stb && out_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected no output", out_char);
          end else begin
            byte e;
            e = exp_q.pop_front();
            check("out_char", out_char, e);
            $display("out byte %02h (expected %02h)", out_char, e);
          end
        end
        prev_stall = out_stb && !out_ack;
        prev_char  = out_char;
      end
    end
  end

  // ---------------- input driver ----------------
  task automatic send_raw(input byte c);
    bit got = 0;
    in_char = c;
    in_stb  = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (in_ack) begin got = 1; break; end
    end
    in_stb = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ack_timeout: char %02h got no in_ack, required one", c);
    end else begin
      @(posedge clk);
      #1;
      check("in_ack_pulse", in_ack, 0);
    end
  endtask

  task automatic settle();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 3; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_stb) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle_timeout: %0d bytes still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      model_char(s[i]);
      send_raw(s[i]);
      settle();
      check($sformatf("error after '%s'[%0d]", s, i), error, m_err);
    end
    $display("expression '%s' done, error=%0d", s, error);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string pool;
    string expr;
    pool = "0123456789+-*/()  =";

    pin("2+1=", "2 1 + =");
    pin("12*3-4=", "12 3 * 4 - =");
    pin("2*(3+4)=", "2 3 4 + * =");
    pin("8/2/2=", "8 2 / 2 / =");
    model_clear();
    model_char(")");
    check("pin_err ')'", m_err, 1);
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("reset out_stb", out_stb, 0);
    check("reset in_ack", in_ack, 0);
    check("reset error", error, 0);
    check("reset out_char", out_char, 0);
    reset = 1'b0;

    ack_mode = 0;
    feed("2+1=");
    feed("12*3-4=");
    feed("2*(3+4)=");
    feed("8/2/2=");

    ack_mode = 2;
    feed("2+1=");

    ack_mode = 1;
    feed(")=");
    feed("(((((((((((((((((");
    feed("=");
    feed("(2=");
    feed("=");

    // Reset in the middle of a stalled output.
    ack_mode = 0;
    feed("3*(");
    ack_mode = 3;
    model_char("4");
    send_raw("4");
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset out_stb", out_stb, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset out_stb", out_stb, 0);
    check("mid_reset error", error, 0);
    model_clear();
    ack_mode = 0;
    feed("5=");

    // Random expressions, including occasional illegal characters.
    ack_mode = 1;
    for (int n = 0; n < 30; n++) begin
      int len;
      expr = "";
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        byte ch;
        if ($urandom_range(0, 40) == 0) ch = "x";
        else ch = pool[$urandom_range(0, pool.len() - 1)];
        expr = {expr, string'(ch)};
      end
      expr = {expr, "="};
      feed(expr);
      if (m_err) feed("=");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
